// File: rtl/interlock_timer_pkg.sv
// Shared types and default timing constants for the interlock timer stage.
package interlock_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        DRAIN = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } timer_state_t;

    localparam int unsigned DEF_TICK_DIV   = 50000000;
    localparam int unsigned DEF_FILL_SECS  = 7;
    localparam int unsigned DEF_DRAIN_SECS = 8;
    localparam int unsigned DEF_WAIT_SECS  = 5;
    localparam int unsigned DEF_CNT_W      = 8;

endpackage

// File: rtl/interlock_timer_if.sv
// Request/finished handshake between the interlock controller (master) and the timer (slave).
interface interlock_timer_if #(
    parameter int unsigned CNT_W = 8
);
  logic             filling;
  logic             draining;
  logic             waiting;
  logic             fillFinished;
  logic             drainFinished;
  logic             waitFinished;
  logic             pressureHigh;
  logic [CNT_W-1:0] secondsLeft;
  logic             busy;

  modport master (
    output filling, draining, waiting,
    input  fillFinished, drainFinished, waitFinished, pressureHigh, secondsLeft, busy
  );

  modport slave (
    input  filling, draining, waiting,
    output fillFinished, drainFinished, waitFinished, pressureHigh, secondsLeft, busy
  );
endinterface

// File: rtl/interlock_timer_tick_prescaler.sv
// Divides clk down to a one-cycle tick every DIV enabled cycles; clear holds the count at zero.
module tick_prescaler #(
    parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // Free-running modulo-DIV count while enabled.
  always_ff @(posedge clk) begin
    if (nReset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end else begin
      count <= count;
    end
  end

  // Decode of the registered count, so the tick lines up with the last cycle of each period.
  assign tick = enable && !clear && (count == LAST);
endmodule

// File: rtl/interlock_timer.sv
// Seconds-countdown and chamber-pressure stage behind the interlock controller.
// Optional macro TIMER_FAST_SIM_EN: prescaler divide forced to 1 (one tick per clk).
module interlock_timer
  import interlock_pkg::*;
#(
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV,
    parameter int unsigned FILL_SECS  = DEF_FILL_SECS,
    parameter int unsigned DRAIN_SECS = DEF_DRAIN_SECS,
    parameter int unsigned WAIT_SECS  = DEF_WAIT_SECS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nReset,
  interlock_timer_if.slave bus
);
`ifdef TIMER_FAST_SIM_EN
  localparam int unsigned EFF_DIV = 1;
`else
  localparam int unsigned EFF_DIV = TICK_DIV;
`endif

  localparam logic [CNT_W-1:0] FILL_CNT  = CNT_W'(FILL_SECS);
  localparam logic [CNT_W-1:0] DRAIN_CNT = CNT_W'(DRAIN_SECS);
  localparam logic [CNT_W-1:0] WAIT_CNT  = CNT_W'(WAIT_SECS);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  timer_state_t     state;
  timer_state_t     job;
  logic [CNT_W-1:0] count;
  logic             in_run;
  logic             active_req;
  logic             tick;

  assign in_run = (state == FILL) || (state == DRAIN) || (state == WAIT);

  // Request level belonging to the run currently owned by the timer.
  always_comb begin
    active_req = 1'b0;
    case (job)
      FILL:    active_req = bus.filling;
      DRAIN:   active_req = bus.draining;
      WAIT:    active_req = bus.waiting;
      default: active_req = 1'b0;
    endcase
  end

  tick_prescaler #(
    .DIV (EFF_DIV)
  ) u_prescaler (
    .clk    (clk),
    .nReset (nReset),
    .clear  (!in_run),
    .enable (in_run),
    .tick   (tick)
  );

  // Timer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (nReset) begin
      state             <= IDLE;
      job               <= IDLE;
      count             <= '0;
      bus.busy          <= 1'b0;
      bus.fillFinished  <= 1'b0;
      bus.drainFinished <= 1'b0;
      bus.waitFinished  <= 1'b0;
      bus.pressureHigh  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.draining) begin
            state    <= DRAIN;
            job      <= DRAIN;
            count    <= DRAIN_CNT;
            bus.busy <= 1'b1;
          end else if (bus.filling) begin
            state    <= FILL;
            job      <= FILL;
            count    <= FILL_CNT;
            bus.busy <= 1'b1;
          end else if (bus.waiting) begin
            state    <= WAIT;
            job      <= WAIT;
            count    <= WAIT_CNT;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            count    <= '0;
            bus.busy <= 1'b0;
          end
        end
        FILL, DRAIN, WAIT: begin
          // A dropped request wins over a completion landing on the same edge.
          if (!active_req) begin
            state    <= IDLE;
            count    <= '0;
            bus.busy <= 1'b0;
          end else if ((count == '0) || (tick && (count == ONE_CNT))) begin
            state    <= DONE;
            count    <= '0;
            bus.busy <= 1'b0;
            case (state)
              FILL: begin
                bus.fillFinished <= 1'b1;
                bus.pressureHigh <= 1'b1;
              end
              DRAIN: begin
                bus.drainFinished <= 1'b1;
                bus.pressureHigh  <= 1'b0;
              end
              default: bus.waitFinished <= 1'b1;
            endcase
          end else if (tick) begin
            count <= count - ONE_CNT;
          end else begin
            count <= count;
          end
        end
        DONE: begin
          if (!active_req) begin
            state             <= IDLE;
            bus.fillFinished  <= 1'b0;
            bus.drainFinished <= 1'b0;
            bus.waitFinished  <= 1'b0;
          end else begin
            state <= DONE;
          end
        end
        default: begin
          state             <= IDLE;
          count             <= '0;
          bus.busy          <= 1'b0;
          bus.fillFinished  <= 1'b0;
          bus.drainFinished <= 1'b0;
          bus.waitFinished  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.secondsLeft = count;
endmodule

// File: tb/tb_interlock_timer.sv
// Self-checking bench: directed scenarios plus random request traffic against an elapsed-time model.
module tb_interlock_timer;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned FILL_SECS  = 3;
  localparam int unsigned DRAIN_SECS = 2;
  localparam int unsigned WAIT_SECS  = 5;
  localparam int unsigned CNT_W      = 8;
`ifdef TIMER_FAST_SIM_EN
  localparam int EFF_DIV = 1;
`else
  localparam int EFF_DIV = TICK_DIV;
`endif

  logic clk;
  logic nReset;
  int   total;
  int   bad;

  interlock_timer_if #(.CNT_W(CNT_W)) bus ();

  interlock_timer #(
    .TICK_DIV   (TICK_DIV),
    .FILL_SECS  (FILL_SECS),
    .DRAIN_SECS (DRAIN_SECS),
    .WAIT_SECS  (WAIT_SECS),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a run is an elapsed-cycle count measured against secs*divide.
  typedef enum int {M_IDLE, M_RUN, M_DONE} mode_t;
  mode_t m_mode;
  int    m_job;
  int    m_elapsed;
  bit    m_ph;

  function automatic int secs_of(input int j);
    case (j)
      0:       return FILL_SECS;
      1:       return DRAIN_SECS;
      default: return WAIT_SECS;
    endcase
  endfunction

  function automatic bit req_of(input int j);
    case (j)
      0:       return bus.filling;
      1:       return bus.draining;
      default: return bus.waiting;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (nReset) begin
      m_mode = M_IDLE; m_elapsed = 0; m_ph = 1'b0; m_job = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (bus.draining)     begin m_job = 1; m_mode = M_RUN; m_elapsed = 0; end
          else if (bus.filling) begin m_job = 0; m_mode = M_RUN; m_elapsed = 0; end
          else if (bus.waiting) begin m_job = 2; m_mode = M_RUN; m_elapsed = 0; end
        end
        M_RUN: begin
          if (!req_of(m_job)) m_mode = M_IDLE;
          else begin
            m_elapsed++;
            if (m_elapsed >= secs_of(m_job) * EFF_DIV) begin
              m_mode = M_DONE;
              if (m_job == 0) m_ph = 1'b1;
              else if (m_job == 1) m_ph = 1'b0;
            end
          end
        end
        default: if (!req_of(m_job)) m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step();
    int exp_left;
    @(posedge clk);
    model_edge();
    #1;
    exp_left = (m_mode == M_RUN) ? secs_of(m_job) - m_elapsed / EFF_DIV : 0;
    check("busy",          32'(bus.busy),          32'(m_mode == M_RUN));
    check("fillFinished",  32'(bus.fillFinished),  32'(m_mode == M_DONE && m_job == 0));
    check("drainFinished", 32'(bus.drainFinished), 32'(m_mode == M_DONE && m_job == 1));
    check("waitFinished",  32'(bus.waitFinished),  32'(m_mode == M_DONE && m_job == 2));
    check("pressureHigh",  32'(bus.pressureHigh),  32'(m_ph));
    check("secondsLeft",   32'(bus.secondsLeft),   32'(exp_left));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    total = 0; bad = 0;
    m_mode = M_IDLE; m_job = 0; m_elapsed = 0; m_ph = 1'b0;
    nReset = 1'b1;
    bus.filling = 1'b0; bus.draining = 1'b0; bus.waiting = 1'b0;
    run(2);
    nReset = 1'b0;
    run(1);
    check("rst_pressure", 32'(bus.pressureHigh), 32'd0);
    check("rst_left",     32'(bus.secondsLeft),  32'd0);

    // Fill from cycle 0, drop at 15, re-request at 16.
    bus.filling = 1'b1;
    run(FILL_SECS * EFF_DIV);
    check("fill_before", 32'(bus.fillFinished), 32'd0);
    run(1);
    check("fill_lat",    32'(bus.fillFinished), 32'd1);
    check("fill_press",  32'(bus.pressureHigh), 32'd1);
    run(2);
    bus.filling = 1'b0;
    run(1);
    check("fill_drop",   32'(bus.fillFinished), 32'd0);
    bus.filling = 1'b1;
    run(1);
    check("fill_reacc",  32'(bus.busy), 32'd1);
    run(FILL_SECS * EFF_DIV);
    check("fill_redund", 32'(bus.pressureHigh), 32'd1);
    bus.filling = 1'b0;
    run(2);

    // Drain after fill.
    bus.draining = 1'b1;
    run(DRAIN_SECS * EFF_DIV + 1);
    check("drain_lat",   32'(bus.drainFinished), 32'd1);
    check("drain_press", 32'(bus.pressureHigh),  32'd0);
    bus.draining = 1'b0;
    run(2);

    // Simultaneous fill and drain: drain first, fill two cycles after drain drops.
    bus.filling = 1'b1; bus.draining = 1'b1;
    run(1);
    check("prio_left", 32'(bus.secondsLeft), 32'(DRAIN_SECS));
    run(DRAIN_SECS * EFF_DIV);
    check("prio_fillign", 32'(bus.fillFinished), 32'd0);
    bus.draining = 1'b0;
    run(1);
    check("prio_dead", 32'(bus.busy), 32'd0);
    run(1);
    check("prio_fill", 32'(bus.secondsLeft), 32'(FILL_SECS));
    run(FILL_SECS * EFF_DIV);
    bus.filling = 1'b0;
    run(2);

    // Abort a wait after 10 cycles.
    bus.waiting = 1'b1;
    run(10);
    bus.waiting = 1'b0;
    run(1);
    check("abort_busy", 32'(bus.busy),         32'd0);
    check("abort_left", 32'(bus.secondsLeft),  32'd0);
    check("abort_fin",  32'(bus.waitFinished), 32'd0);
    check("abort_pres", 32'(bus.pressureHigh), 32'd1);
    run(1);

    // Reset mid-fill, then a full restart while filling stays high.
    bus.filling = 1'b1;
    run(6);
    nReset = 1'b1;
    run(1);
    check("mrst_busy",  32'(bus.busy),         32'd0);
    check("mrst_press", 32'(bus.pressureHigh), 32'd0);
    nReset = 1'b0;
    run(FILL_SECS * EFF_DIV);
    check("mrst_early", 32'(bus.fillFinished), 32'd0);
    run(1);
    check("mrst_full",  32'(bus.fillFinished), 32'd1);
    bus.filling = 1'b0;
    run(2);

    // Random request traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      nReset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 24) == 0) bus.filling  = ~bus.filling;
      if ($urandom_range(0, 24) == 0) bus.draining = ~bus.draining;
      if ($urandom_range(0, 24) == 0) bus.waiting  = ~bus.waiting;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
